// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use stalls, taken-branch squash, EX forwarding.
// Optional HAZARD_STATS_EN adds saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int unsigned REG_W    = 2,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [REG_W-1:0] id_src,
    input  logic             id_src_valid,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_wr,
    input  logic             ex_rm,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_wr,
    input  logic             branch_taken,
    output logic             stall,
    output logic             bubble_idex,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic [1:0]       fwd,
    output logic [15:0]      stall_cnt,
    output logic [15:0]      flush_cnt
);

    typedef enum logic [0:0] {StRun, StLoadWait} state_e;

    localparam logic [2:0] WaitInit = 3'(LOAD_LAT - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] fwd_q, fwd_d;

    logic load_use;
    logic ex_match;
    logic mem_match;

    assign ex_match  = id_src_valid & ex_wr & (id_src == ex_rd);
    assign mem_match = id_src_valid & mem_wr & (id_src == mem_rd);
    assign load_use  = ex_match & ex_rm;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fwd_d       = 2'b00;
        stall       = 1'b1;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        // Controls stay quiescent while reset is asserted, whatever the inputs.
        if (reset_n) begin
            unique case (state_q)
                StRun: begin
                    if (branch_taken) begin
                        flush_ifid  = 1'b1;
                        flush_idex  = 1'b1;
                        flush_exmem = 1'b1;
                    end else if (load_use) begin
                        stall       = 1'b0;
                        bubble_idex = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = StLoadWait;
                            cnt_d   = WaitInit;
                        end
                    end else if (ex_match) begin
                        fwd_d = 2'b01;
                    end else if (mem_match) begin
                        fwd_d = 2'b10;
                    end
                end
                StLoadWait: begin
                    if (branch_taken) begin
                        flush_ifid  = 1'b1;
                        flush_idex  = 1'b1;
                        flush_exmem = 1'b1;
                        state_d     = StRun;
                        cnt_d       = 3'd0;
                    end else begin
                        stall       = 1'b0;
                        bubble_idex = 1'b1;
                        cnt_d       = cnt_q - 3'd1;
                        if (cnt_q == 3'd1) begin
                            state_d = StRun;
                        end
                    end
                end
                default: begin
                    state_d = StRun;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StRun;
            cnt_q   <= 3'd0;
            fwd_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fwd_q   <= fwd_d;
        end
    end

    assign fwd = fwd_q;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            if (!stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (flush_ifid && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 16'h0000;
    assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LOAD_LAT=1 and 3) on shared stimulus, checked every
// cycle against a remaining-stall-cycles model plus hand-computed literal expectations.
module tb_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [1:0] id_src, ex_rd, mem_rd;
    logic       id_src_valid, ex_wr, ex_rm, mem_wr, branch_taken;

    logic [1:0]  stall_w, bubble_w, fl_ifid_w, fl_idex_w, fl_exmem_w;
    logic [1:0]  fwd_w   [2];
    logic [15:0] scnt_w  [2];
    logic [15:0] fcnt_w  [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    hazard_ctrl #(.REG_W(2), .LOAD_LAT(1)) dut (
        .clock(clock), .reset_n(reset_n), .id_src(id_src), .id_src_valid(id_src_valid),
        .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_rm(ex_rm), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .branch_taken(branch_taken), .stall(stall_w[0]), .bubble_idex(bubble_w[0]),
        .flush_ifid(fl_ifid_w[0]), .flush_idex(fl_idex_w[0]), .flush_exmem(fl_exmem_w[0]),
        .fwd(fwd_w[0]), .stall_cnt(scnt_w[0]), .flush_cnt(fcnt_w[0])
    );

    hazard_ctrl #(.REG_W(2), .LOAD_LAT(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .id_src(id_src), .id_src_valid(id_src_valid),
        .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_rm(ex_rm), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .branch_taken(branch_taken), .stall(stall_w[1]), .bubble_idex(bubble_w[1]),
        .flush_ifid(fl_ifid_w[1]), .flush_idex(fl_idex_w[1]), .flush_exmem(fl_exmem_w[1]),
        .fwd(fwd_w[1]), .stall_cnt(scnt_w[1]), .flush_cnt(fcnt_w[1])
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Model: per instance, how many more stall cycles are owed, plus expected fwd and counters.
    int          lat   [2] = '{1, 3};
    int          left  [2];
    logic [1:0]  m_fwd [2];
    int unsigned m_scnt[2];
    int unsigned m_fcnt[2];

    function automatic logic lu();
        return id_src_valid && ex_rm && ex_wr && (id_src == ex_rd);
    endfunction

    function automatic void expect_ctrl(input int k, output logic e_stall, output logic e_bub,
                                        output logic e_flush);
        e_stall = 1'b1; e_bub = 1'b0; e_flush = 1'b0;
        if (reset_n) begin
            if (branch_taken) e_flush = 1'b1;
            else if (left[k] > 0 || lu()) begin
                e_stall = 1'b0; e_bub = 1'b1;
            end
        end
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                left[k] = 0; m_fwd[k] = 2'b00; m_scnt[k] = 0; m_fcnt[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic es, eb, ef;
                expect_ctrl(k, es, eb, ef);
`ifdef HAZARD_STATS_EN
                if (!es && m_scnt[k] < 32'hFFFF) m_scnt[k]++;
                if (ef && m_fcnt[k] < 32'hFFFF) m_fcnt[k]++;
`endif
                if (branch_taken) begin
                    left[k] = 0; m_fwd[k] = 2'b00;
                end else if (left[k] > 0) begin
                    left[k]--; m_fwd[k] = 2'b00;
                end else if (lu()) begin
                    left[k] = lat[k] - 1; m_fwd[k] = 2'b00;
                end else if (id_src_valid && ex_wr && id_src == ex_rd) m_fwd[k] = 2'b01;
                else if (id_src_valid && mem_wr && id_src == mem_rd) m_fwd[k] = 2'b10;
                else m_fwd[k] = 2'b00;
            end
        end
    end

    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            logic es, eb, ef;
            expect_ctrl(k, es, eb, ef);
            check($sformatf("stall[%0d]", k), 16'(stall_w[k]), 16'(es));
            check($sformatf("bubble_idex[%0d]", k), 16'(bubble_w[k]), 16'(eb));
            check($sformatf("flush_ifid[%0d]", k), 16'(fl_ifid_w[k]), 16'(ef));
            check($sformatf("flush_idex[%0d]", k), 16'(fl_idex_w[k]), 16'(ef));
            check($sformatf("flush_exmem[%0d]", k), 16'(fl_exmem_w[k]), 16'(ef));
            check($sformatf("fwd[%0d]", k), 16'(fwd_w[k]), 16'(m_fwd[k]));
            check($sformatf("stall_cnt[%0d]", k), scnt_w[k], 16'(m_scnt[k]));
            check($sformatf("flush_cnt[%0d]", k), fcnt_w[k], 16'(m_fcnt[k]));
        end
    end

    task automatic drive(input logic [1:0] src, input logic srcv, input logic [1:0] erd,
                         input logic ewr, input logic erm, input logic [1:0] mrd,
                         input logic mwr, input logic br);
        id_src = src; id_src_valid = srcv; ex_rd = erd; ex_wr = ewr; ex_rm = erm;
        mem_rd = mrd; mem_wr = mwr; branch_taken = br;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    logic [15:0] sat_exp;
    int          zeros3;

    initial begin
        // Reset held with branch and load-use both asserted on the inputs.
        reset_n = 1'b0;
        drive(2'd1, 1'b1, 2'd1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1);
        repeat (3) @(negedge clock);
        check("rst_stall", 16'(stall_w[0]), 16'd1);
        check("rst_bubble", 16'(bubble_w[0]), 16'd0);
        check("rst_flush", 16'(fl_ifid_w[1]), 16'd0);
        check("rst_fwd", 16'(fwd_w[0]), 16'd0);
        check("rst_scnt", scnt_w[0], 16'd0);

        next_cycle();
        reset_n = 1'b1;
        drive(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        // EX/MEM and MEM/WB both match: newest producer wins.
        next_cycle();
        drive(2'd2, 1'b1, 2'd2, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0);
        @(negedge clock);
        check("exfwd_stall", 16'(stall_w[0]), 16'd1);
        next_cycle();
        drive(2'd2, 1'b1, 2'd2, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0);
        @(negedge clock);
        check("exfwd_fwd", 16'(fwd_w[0]), 16'h1);
        next_cycle();
        drive(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        @(negedge clock);
        check("memfwd_fwd", 16'(fwd_w[0]), 16'h2);

        // Load-use hazard.
        next_cycle();
        zeros3 = 0;
        drive(2'd1, 1'b1, 2'd1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        @(negedge clock);
        check("lu_stall", 16'(stall_w[0]), 16'd0);
        check("lu_bubble", 16'(bubble_w[0]), 16'd1);
        zeros3 += (stall_w[1] == 1'b0) ? 1 : 0;
        next_cycle();
        drive(2'd1, 1'b1, 2'd1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
        @(negedge clock);
        check("lu_release", 16'(stall_w[0]), 16'd1);
`ifdef HAZARD_STATS_EN
        check("lu_scnt", scnt_w[0], 16'd1);
`else
        check("lu_scnt", scnt_w[0], 16'd0);
`endif
        zeros3 += (stall_w[1] == 1'b0) ? 1 : 0;
        next_cycle();
        @(negedge clock);
        check("lu_fwd", 16'(fwd_w[0]), 16'h2);
        zeros3 += (stall_w[1] == 1'b0) ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            @(negedge clock);
            if (stall_w[1]) break;
            zeros3++;
        end
        check("lat3_stall_cycles", 16'(zeros3), 16'd3);

        // Branch arriving in the second LOAD_LAT=3 stall cycle.
        next_cycle();
        drive(2'd1, 1'b1, 2'd1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        next_cycle();
        drive(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        @(negedge clock);
        check("br_flush_ifid", 16'(fl_ifid_w[1]), 16'd1);
        check("br_flush_exmem", 16'(fl_exmem_w[1]), 16'd1);
        check("br_stall", 16'(stall_w[1]), 16'd1);
        next_cycle();
        drive(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        @(negedge clock);
        check("br_run_stall", 16'(stall_w[1]), 16'd1);
        check("br_fwd", 16'(fwd_w[1]), 16'd0);
`ifdef HAZARD_STATS_EN
        check("br_fcnt", fcnt_w[1], 16'd1);
`else
        check("br_fcnt", fcnt_w[1], 16'd0);
`endif

        // Corner vectors: load without match, rd match without write, invalid source,
        // MEM-only match, dual match.
        next_cycle(); drive(2'd0, 1'b1, 2'd3, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
        next_cycle(); drive(2'd3, 1'b1, 2'd3, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
        next_cycle(); drive(2'd2, 1'b0, 2'd2, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0);
        next_cycle(); drive(2'd3, 1'b1, 2'd1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0);
        next_cycle(); drive(2'd0, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
        next_cycle(); drive(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        // Saturation: hold a load-use hazard long enough to overflow the counter.
        next_cycle();
        drive(2'd1, 1'b1, 2'd1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        repeat (65540) @(posedge clock);
        #1;
        drive(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        @(negedge clock);
`ifdef HAZARD_STATS_EN
        sat_exp = 16'hFFFF;
`else
        sat_exp = 16'h0000;
`endif
        check("sat_scnt1", scnt_w[0], sat_exp);
        check("sat_scnt3", scnt_w[1], sat_exp);

        next_cycle();
        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
